// File: rtl/mfp_uart_word_loader_pkg.sv
// Shared definitions for the UART word loader: default timing, base address,
// RX state encodings and the little-endian byte packing helper.
package mfp_uart_word_loader_pkg;

    localparam int          DEF_CLKS_PER_BIT   = 434;
    localparam logic [31:0] DEF_BASE_ADDR      = 32'h0000_0000;
    localparam int          DEF_TIMEOUT_CYCLES = 5_000_000;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Places byte b at lane idx of the partially packed word held in shift.
    function automatic logic [31:0] insert_byte(input logic [23:0] shift,
                                                input logic [7:0]  b,
                                                input logic [1:0]  idx);
        logic [31:0] w;
        w = {8'h00, shift};
        w[8*idx +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/mfp_uart_word_loader_if.sv
// RAM write-port bundle driven by the loader, plus its session and error status.
interface mfp_uart_word_loader_if;
    logic        LOAD_Write;
    logic [31:0] LOAD_Addr;
    logic [31:0] LOAD_Data;
    logic        LOAD_Ready;
    logic        LOAD_Active;
    logic        LOAD_FrameErr;
    logic        LOAD_Overrun;

    modport master (
        output LOAD_Write, LOAD_Addr, LOAD_Data, LOAD_Active, LOAD_FrameErr, LOAD_Overrun,
        input  LOAD_Ready
    );

    modport slave (
        input  LOAD_Write, LOAD_Addr, LOAD_Data, LOAD_Active, LOAD_FrameErr, LOAD_Overrun,
        output LOAD_Ready
    );
endinterface

// File: rtl/mfp_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling FSM, one-cycle
// byte_valid / frame_err pulses.
module mfp_uart_rx_byte
    import mfp_uart_word_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       SI_ClkIn,
    input  logic       SI_Reset,
    input  logic       UART_RX,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_reg;
    logic          rx_prev_reg;
    rx_state_e     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    data_reg, data_next;
    logic          valid_reg, valid_next;
    logic          ferr_reg, ferr_next;
    logic          rx_bit;

    assign rx_bit = sync_reg[1];

    always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
        if (SI_Reset) begin
            sync_reg    <= 2'b11;
            rx_prev_reg <= 1'b1;
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], UART_RX};
            rx_prev_reg <= rx_bit;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                cnt_next = '0;
                if (rx_prev_reg && !rx_bit) state_next = RX_START;
            end
            RX_START: begin
                // Re-check at mid start bit; a high line here was only a glitch.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_bit ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next     = '0;
                    data_next    = {rx_bit, data_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next = '0;
                    if (rx_bit) begin
                        valid_next = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                cnt_next = '0;
                if (rx_bit) state_next = RX_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = RX_IDLE;
            end
        endcase
    end

    assign byte_valid = valid_reg;
    assign byte_data  = data_reg;
    assign frame_err  = ferr_reg;

endmodule

// File: rtl/mfp_uart_word_loader.sv
// Boot loader: packs received UART bytes into little-endian words and writes them
// to consecutive RAM addresses, holding the core in reset for the session.
module mfp_uart_word_loader
    import mfp_uart_word_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT   = DEF_CLKS_PER_BIT,
    parameter logic [31:0] BASE_ADDR      = DEF_BASE_ADDR,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          SI_ClkIn,
    input  logic                          SI_Reset,
    input  logic                          UART_RX,
    mfp_uart_word_loader_if.master        load
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES);

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          frame_err_pulse;

    logic          write_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   data_reg;
    logic          active_reg;
    logic          frame_err_reg;
    logic          overrun_reg;
    logic [1:0]    byte_cnt_reg;
    logic [23:0]   shift_reg;
    logic [TW-1:0] idle_cnt_reg;

    logic          accept;
    logic          write_pending;
    logic [31:0]   word_w;

    mfp_uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .SI_ClkIn   (SI_ClkIn),
        .SI_Reset   (SI_Reset),
        .UART_RX    (UART_RX),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err_pulse)
    );

    assign accept        = write_reg && load.LOAD_Ready;
    // A write accepted this cycle frees the slot for a word completing in the same cycle.
    assign write_pending = write_reg && !accept;
    assign word_w        = insert_byte(shift_reg, byte_data, byte_cnt_reg);

    always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
        if (SI_Reset) begin
            write_reg     <= 1'b0;
            addr_reg      <= BASE_ADDR;
            data_reg      <= '0;
            active_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            byte_cnt_reg  <= '0;
            shift_reg     <= '0;
            idle_cnt_reg  <= '0;
        end else begin
            if (frame_err_pulse) frame_err_reg <= 1'b1;

            if (accept) begin
                write_reg <= 1'b0;
                addr_reg  <= addr_reg + 32'd4;
            end

            if (byte_valid) begin
                idle_cnt_reg <= '0;
                if (!active_reg) begin
                    active_reg   <= 1'b1;
                    addr_reg     <= BASE_ADDR;
                    shift_reg    <= {16'h0000, byte_data};
                    byte_cnt_reg <= 2'd1;
                end else begin
                    shift_reg    <= word_w[23:0];
                    byte_cnt_reg <= byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        if (write_pending) begin
                            overrun_reg <= 1'b1;
                        end else begin
                            data_reg  <= word_w;
                            write_reg <= 1'b1;
                        end
                    end
                end
            end else if (active_reg) begin
                // Saturate at the limit; the session only ends once no write is outstanding.
                if (idle_cnt_reg == IDLE_LIMIT) begin
                    if (!write_reg) begin
                        active_reg   <= 1'b0;
                        byte_cnt_reg <= '0;
                        idle_cnt_reg <= '0;
                    end
                end else begin
                    idle_cnt_reg <= idle_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign load.LOAD_Write    = write_reg;
    assign load.LOAD_Addr     = addr_reg;
    assign load.LOAD_Data     = data_reg;
    assign load.LOAD_Active   = active_reg;
    assign load.LOAD_FrameErr = frame_err_reg;
    assign load.LOAD_Overrun  = overrun_reg;

endmodule

// File: tb/tb_mfp_uart_word_loader.sv
// Directed bench for the UART word loader: word packing, handshake stalls, glitch
// rejection, framing errors, session timeout, overrun and mid-byte reset.
module tb_mfp_uart_word_loader;
    localparam int CPB     = 4;
    localparam int TIMEOUT = 200;

    logic SI_ClkIn;
    logic SI_Reset;
    logic UART_RX;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    mfp_uart_word_loader_if bus();

    mfp_uart_word_loader #(
        .CLKS_PER_BIT   (CPB),
        .BASE_ADDR      (32'h0000_0000),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .SI_ClkIn (SI_ClkIn),
        .SI_Reset (SI_Reset),
        .UART_RX  (UART_RX),
        .load     (bus)
    );

    initial SI_ClkIn = 1'b0;
    always #5 SI_ClkIn = ~SI_ClkIn;

    // Record every accepted write (sampled half a cycle before the accepting edge).
    always @(negedge SI_ClkIn) begin
        if (!SI_Reset && bus.LOAD_Write && bus.LOAD_Ready) begin
            wr_addr_q.push_back(bus.LOAD_Addr);
            wr_data_q.push_back(bus.LOAD_Data);
            $display("[TB] write addr=%08h data=%08h", bus.LOAD_Addr, bus.LOAD_Data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge SI_ClkIn);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge SI_ClkIn);
        UART_RX = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            wait_cycles(CPB);
        end
        UART_RX = stop_bit;
        wait_cycles(CPB);
        UART_RX = 1'b1;
        wait_cycles(CPB);
        $display("[TB] sent byte %02h stop=%0b", b, stop_bit);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    initial begin
        int n;
        SI_Reset = 1'b1;
        UART_RX  = 1'b1;
        bus.LOAD_Ready = 1'b1;
        wait_cycles(3);

        // Reset state
        check("rst_write",  {31'd0, bus.LOAD_Write},    32'd0);
        check("rst_addr",   bus.LOAD_Addr,              32'h0);
        check("rst_data",   bus.LOAD_Data,              32'h0);
        check("rst_active", {31'd0, bus.LOAD_Active},   32'd0);
        check("rst_ferr",   {31'd0, bus.LOAD_FrameErr}, 32'd0);
        check("rst_ovr",    {31'd0, bus.LOAD_Overrun},  32'd0);
        SI_Reset = 1'b0;
        wait_cycles(4);

        // 1. Two words, then session timeout
        send_word(32'h1234_5678);
        check("t1_active", {31'd0, bus.LOAD_Active}, 32'd1);
        send_word(32'hDEAD_BEEF);
        check("t1_wcount", wr_data_q.size(), 32'd2);
        check("t1_addr0",  wr_addr_q[0], 32'h0000_0000);
        check("t1_data0",  wr_data_q[0], 32'h1234_5678);
        check("t1_addr1",  wr_addr_q[1], 32'h0000_0004);
        check("t1_data1",  wr_data_q[1], 32'hDEAD_BEEF);
        wait_cycles(180);
        check("t1_active_before_to", {31'd0, bus.LOAD_Active}, 32'd1);
        wait_cycles(40);
        check("t1_active_after_to",  {31'd0, bus.LOAD_Active}, 32'd0);

        // 2. Sink stalls the first word for 50 cycles
        n = wr_data_q.size();
        bus.LOAD_Ready = 1'b0;
        send_word(32'h1122_3344);
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 0) begin
                check("t2_stall_write", {31'd0, bus.LOAD_Write}, 32'd1);
                check("t2_stall_addr",  bus.LOAD_Addr, 32'h0000_0000);
                check("t2_stall_data",  bus.LOAD_Data, 32'h1122_3344);
            end
            wait_cycles(1);
        end
        bus.LOAD_Ready = 1'b1;
        wait_cycles(2);
        check("t2_wcount",  wr_data_q.size() - n, 32'd1);
        check("t2_write_0", {31'd0, bus.LOAD_Write}, 32'd0);
        check("t2_addr4",   bus.LOAD_Addr, 32'h0000_0004);
        wait_cycles(230);
        check("t2_active_to", {31'd0, bus.LOAD_Active}, 32'd0);

        // 3. One-cycle glitch on the line
        n = wr_data_q.size();
        @(negedge SI_ClkIn);
        UART_RX = 1'b0;
        @(negedge SI_ClkIn);
        UART_RX = 1'b1;
        wait_cycles(20);
        check("t3_active", {31'd0, bus.LOAD_Active},   32'd0);
        check("t3_ferr",   {31'd0, bus.LOAD_FrameErr}, 32'd0);
        check("t3_wcount", wr_data_q.size() - n, 32'd0);

        // 4. Framing error, then a good word
        send_byte(8'hA5, 1'b0);
        check("t4_ferr",   {31'd0, bus.LOAD_FrameErr}, 32'd1);
        check("t4_active", {31'd0, bus.LOAD_Active},   32'd0);
        n = wr_data_q.size();
        send_word(32'h0403_0201);
        check("t4_wcount", wr_data_q.size() - n, 32'd1);
        check("t4_addr",   wr_addr_q[n], 32'h0000_0000);
        check("t4_data",   wr_data_q[n], 32'h0403_0201);
        check("t4_ferr_sticky", {31'd0, bus.LOAD_FrameErr}, 32'd1);
        wait_cycles(230);

        // 5. Partial word discarded by timeout, new session starts at base
        n = wr_data_q.size();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("t5_active_on", {31'd0, bus.LOAD_Active}, 32'd1);
        wait_cycles(230);
        check("t5_active_to", {31'd0, bus.LOAD_Active}, 32'd0);
        check("t5_nowrite",   wr_data_q.size() - n, 32'd0);
        send_word(32'h0000_0001);
        check("t5_wcount", wr_data_q.size() - n, 32'd1);
        check("t5_addr",   wr_addr_q[n], 32'h0000_0000);
        check("t5_data",   wr_data_q[n], 32'h0000_0001);
        wait_cycles(230);

        // 6. Overrun while the first word is stalled
        n = wr_data_q.size();
        bus.LOAD_Ready = 1'b0;
        send_word(32'hDDCC_BBAA);
        check("t6_no_ovr_yet", {31'd0, bus.LOAD_Overrun}, 32'd0);
        send_word(32'h4433_2211);
        check("t6_ovr",        {31'd0, bus.LOAD_Overrun}, 32'd1);
        check("t6_data_kept",  bus.LOAD_Data, 32'hDDCC_BBAA);
        bus.LOAD_Ready = 1'b1;
        wait_cycles(3);
        check("t6_wcount",  wr_data_q.size() - n, 32'd1);
        check("t6_addr",    wr_addr_q[n], 32'h0000_0000);
        check("t6_data",    wr_data_q[n], 32'hDDCC_BBAA);
        check("t6_write_0", {31'd0, bus.LOAD_Write}, 32'd0);

        // Stall another word, then reset in the middle of a byte
        bus.LOAD_Ready = 1'b0;
        send_word(32'h8877_6655);
        check("t6_pend_write", {31'd0, bus.LOAD_Write}, 32'd1);
        check("t6_pend_addr",  bus.LOAD_Addr, 32'h0000_0004);
        @(negedge SI_ClkIn);
        UART_RX = 1'b0;
        wait_cycles(10);
        SI_Reset = 1'b1;
        wait_cycles(1);
        check("t6_rst_write",  {31'd0, bus.LOAD_Write},    32'd0);
        check("t6_rst_addr",   bus.LOAD_Addr,              32'h0);
        check("t6_rst_data",   bus.LOAD_Data,              32'h0);
        check("t6_rst_active", {31'd0, bus.LOAD_Active},   32'd0);
        check("t6_rst_ferr",   {31'd0, bus.LOAD_FrameErr}, 32'd0);
        check("t6_rst_ovr",    {31'd0, bus.LOAD_Overrun},  32'd0);
        UART_RX = 1'b1;
        wait_cycles(3);
        SI_Reset = 1'b0;
        n = wr_data_q.size();
        bus.LOAD_Ready = 1'b1;
        wait_cycles(60);
        check("t6_post_nowrite", wr_data_q.size() - n, 32'd0);
        check("t6_post_active",  {31'd0, bus.LOAD_Active}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
